game_soc_keycode_in: RTL and testbench

GAME_SOC_KEYCODE_IN -- requirements
Module: game_soc_keycode_in

---
 rtl/game_soc_keycode_in_if.sv | 22 ++
 rtl/game_soc_keycode_in.sv | 103 ++++++++++
 tb/tb_game_soc_keycode_in.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/game_soc_keycode_in_if.sv
// Avalon-MM slave bus bundle for the keycode FIFO.
// master drives address/strobes/writedata; slave returns readdata.
interface game_soc_keycode_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, read_n,
    output write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, read_n,
    input  write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/game_soc_keycode_in.sv
// Keycode input FIFO with Avalon-MM DATA/STATUS/IRQ_MASK/FLUSH regs.
// Ports: clk, reset (sync, high), bus (slave), in_port/in_valid, irq.
module game_soc_keycode_in #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset,
  game_soc_keycode_in_if.slave bus,
  input  logic [WIDTH-1:0] in_port,
  input  logic             in_valid,
  output logic             irq
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             overflow;
  logic [1:0]       mask;

  logic empty, full;
  logic rd, wr, pop, push;
  logic flush, ovf_evt, ovf_clr;
  logic unused_wd;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  assign rd = bus.chipselect & ~bus.read_n;
  assign wr = bus.chipselect & ~bus.write_n;

  assign pop   = rd & (bus.address == 2'd0) & ~empty;
  // A pop in the same cycle frees the slot for the push.
  assign push  = in_valid & (~full | pop);
  assign flush = wr & (bus.address == 2'd3);

  assign ovf_evt = in_valid & full & ~pop;
  assign ovf_clr = wr & (bus.address == 2'd1)
                 & bus.writedata[18];

  assign unused_wd = ^{bus.writedata[31:19],
                       bus.writedata[17:2]};

  always_ff @(posedge clk) begin
    if (push & ~flush & ~reset)
      mem[wr_ptr] <= in_port;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      mask     <= 2'b00;
    end else begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (push & ~pop)
          count <= count + 1'b1;
        else if (pop & ~push)
          count <= count - 1'b1;
      end
      // Set beats clear when both happen together.
      if (ovf_evt)
        overflow <= 1'b1;
      else if (ovf_clr)
        overflow <= 1'b0;
      if (wr & (bus.address == 2'd2))
        mask <= bus.writedata[1:0];
    end
  end

  always_comb begin
    bus.readdata = '0;
    unique case (bus.address)
      2'd0: begin
        if (!empty) begin
          bus.readdata[WIDTH-1:0] = mem[rd_ptr];
          bus.readdata[31]        = 1'b1;
        end
      end
      2'd1: begin
        bus.readdata[CW-1:0] = count;
        bus.readdata[16]     = empty;
        bus.readdata[17]     = full;
        bus.readdata[18]     = overflow;
      end
      2'd2: bus.readdata[1:0] = mask;
      default: bus.readdata = '0;
    endcase
  end

  assign irq = (mask[0] & ~empty) | (mask[1] & overflow);
endmodule

// File: tb/tb_game_soc_keycode_in.sv
// Testbench for game_soc_keycode_in: directed scenarios plus
// random traffic checked against a queue-based reference model.
module tb_game_soc_keycode_in;
  localparam int DEPTH = 16;
  localparam int WIDTH = 24;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] in_port;
  logic             in_valid;
  logic             irq;

  game_soc_keycode_in_if bus();

  always #5 clk = ~clk;

  game_soc_keycode_in #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .in_port  (in_port),
    .in_valid (in_valid),
    .irq      (irq)
  );

  int checks = 0;
  int errors = 0;

  int unsigned q[$];
  bit          ovf;
  bit [1:0]    mask;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(logic [1:0] a);
    logic [31:0] r;
    r = 32'h0;
    case (a)
      2'd0: if (q.size() > 0) r = 32'h8000_0000 | q[0];
      2'd1: begin
        r = q.size();
        if (q.size() == 0)     r = r | 32'h0001_0000;
        if (q.size() == DEPTH) r = r | 32'h0002_0000;
        if (ovf)               r = r | 32'h0004_0000;
      end
      2'd2: r = {30'b0, mask};
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  function automatic logic model_irq();
    return (mask[0] && q.size() > 0) || (mask[1] && ovf);
  endfunction

  // One clock cycle: drive, check outputs vs model, clock, update model.
  task automatic step(bit rst, logic [1:0] a, bit r, bit w,
                      logic [31:0] wd, bit kv,
                      logic [WIDTH-1:0] kd, string tag,
                      output logic [31:0] rdv);
    bit popped, fl, evt;
    reset          = rst;
    bus.address    = a;
    bus.chipselect = r | w;
    bus.read_n     = ~r;
    bus.write_n    = ~w;
    bus.writedata  = wd;
    in_valid       = kv;
    in_port        = kd;
    #3;
    rdv = bus.readdata;
    chk({tag, "/rd"}, bus.readdata, model_rd(a));
    chk({tag, "/irq"}, {31'b0, irq}, {31'b0, model_irq()});
    @(posedge clk);
    if (rst) begin
      q.delete();
      ovf  = 0;
      mask = 0;
    end else begin
      popped = r && a == 2'd0 && q.size() > 0;
      fl     = w && a == 2'd3;
      evt    = kv && q.size() == DEPTH && !popped;
      if (fl) q.delete();
      else begin
        if (popped) void'(q.pop_front());
        if (kv && q.size() < DEPTH) q.push_back(32'(kd));
      end
      if (evt) ovf = 1;
      else if (w && a == 2'd1 && wd[18]) ovf = 0;
      if (w && a == 2'd2) mask = wd[1:0];
    end
    #1;
    bus.chipselect = 1'b0;
    bus.read_n     = 1'b1;
    bus.write_n    = 1'b1;
    in_valid       = 1'b0;
    reset          = 1'b0;
  endtask

  // Side-effect-free look at a register, compared to a constant.
  task automatic expect_reg(string tag, logic [1:0] a,
                            logic [31:0] exp);
    bus.address    = a;
    bus.chipselect = 1'b0;
    #1;
    chk(tag, bus.readdata, exp);
  endtask

  task automatic expect_irq(string tag, logic exp);
    #1;
    chk(tag, {31'b0, irq}, {31'b0, exp});
  endtask

  logic [31:0] v;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_port = '0;
    bus.address = 2'd0; bus.chipselect = 1'b0;
    bus.read_n = 1'b1; bus.write_n = 1'b1;
    bus.writedata = 32'h0;
    q.delete(); ovf = 0; mask = 0;
    @(posedge clk); #1;
    step(1, 0, 0, 0, 0, 0, 0, "rst", v);
    expect_reg("rst_data", 0, 32'h0000_0000);
    expect_reg("rst_status", 1, 32'h0001_0000);
    expect_reg("rst_mask", 2, 32'h0);
    expect_irq("rst_irq", 1'b0);

    // Two pushes, two pops, empty read.
    step(0, 0, 0, 0, 0, 1, 24'h00001C, "p1", v);
    step(0, 0, 0, 0, 0, 1, 24'h000032, "p2", v);
    step(0, 0, 1, 0, 0, 0, 0, "r1", v);
    chk("basic_rd1", v, 32'h8000_001C);
    step(0, 0, 1, 0, 0, 0, 0, "r2", v);
    chk("basic_rd2", v, 32'h8000_0032);
    step(0, 0, 1, 0, 0, 0, 0, "r3", v);
    chk("basic_rd3", v, 32'h0000_0000);
    expect_reg("basic_status", 1, 32'h0001_0000);

    // Overfill: 17 pushes, 17th dropped.
    for (int i = 0; i < 17; i++)
      step(0, 1, 0, 0, 0, 1, 24'(32'h100 + i), "fill", v);
    expect_reg("ovf_status", 1, 32'h0006_0010);
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 1, 0, 0, 0, 0, "drain", v);
      chk("ovf_order", v, 32'h8000_0100 + i);
    end
    expect_reg("ovf_empty", 1, 32'h0005_0000);
    step(0, 1, 0, 1, 32'h0004_0000, 0, 0, "clr", v);
    expect_reg("ovf_cleared", 1, 32'h0001_0000);

    // Full with simultaneous push and pop.
    for (int i = 0; i < 16; i++)
      step(0, 1, 0, 0, 0, 1, 24'(32'h200 + i), "fill2", v);
    step(0, 0, 1, 0, 0, 1, 24'h0002FF, "pushpop", v);
    chk("pp_head", v, 32'h8000_0200);
    expect_reg("pp_status", 1, 32'h0002_0010);
    for (int i = 1; i < 16; i++) begin
      step(0, 0, 1, 0, 0, 0, 0, "drain2", v);
      chk("pp_order", v, 32'h8000_0200 + i);
    end
    step(0, 0, 1, 0, 0, 0, 0, "drain2l", v);
    chk("pp_last", v, 32'h8000_02FF);

    // Not-empty interrupt.
    step(0, 2, 0, 1, 32'h1, 0, 0, "mask1", v);
    expect_irq("irq_empty", 1'b0);
    step(0, 1, 0, 0, 0, 1, 24'h00ABCD, "ipush", v);
    expect_irq("irq_push", 1'b1);
    step(0, 0, 1, 0, 0, 0, 0, "ipop", v);
    expect_irq("irq_pop", 1'b0);

    // Overflow interrupt and clear-vs-set priority.
    step(0, 2, 0, 1, 32'h2, 0, 0, "mask2", v);
    for (int i = 0; i < 17; i++)
      step(0, 1, 0, 0, 0, 1, 24'(32'h300 + i), "fill3", v);
    expect_irq("irq_ovf", 1'b1);
    step(0, 1, 0, 1, 32'h0004_0000, 0, 0, "clr2", v);
    expect_reg("clr_status", 1, 32'h0002_0010);
    expect_irq("irq_clr", 1'b0);
    step(0, 1, 0, 1, 32'h0004_0000, 1, 24'h3FF, "clrset", v);
    expect_reg("set_wins", 1, 32'h0006_0010);

    // Flush with concurrent push, then reset mid-stream.
    step(0, 3, 0, 1, 32'h0, 0, 0, "flush0", v);
    for (int i = 0; i < 5; i++)
      step(0, 1, 0, 0, 0, 1, 24'(32'h400 + i), "fill4", v);
    expect_reg("cnt5", 1, 32'h0004_0005);
    step(0, 3, 0, 1, 32'hDEAD_BEEF, 1, 24'h4FF, "flush", v);
    expect_reg("flush_status", 1, 32'h0005_0000);
    expect_reg("flush_mask", 2, 32'h2);
    step(0, 1, 0, 0, 0, 1, 24'h500, "p5", v);
    step(1, 0, 1, 1, 32'h3, 1, 24'h501, "rstmid", v);
    expect_reg("rst_mid", 1, 32'h0001_0000);
    expect_irq("rst_mid_irq", 1'b0);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      bit rr, ww, kk, rs;
      logic [1:0] aa;
      logic [31:0] wd;
      rs = ($urandom_range(0, 99) == 0);
      aa = 2'($urandom_range(0, 3));
      rr = ($urandom_range(0, 2) == 0);
      ww = !rr && ($urandom_range(0, 5) == 0);
      kk = ($urandom_range(0, 1) == 1);
      wd = $urandom;
      step(rs, aa, rr, ww, wd, kk, 24'($urandom), "rand", v);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
